// File: rtl/fifo_frame_rd_ctrl.sv
// Read-side frame scheduler for the dual-clock audio FIFO (read clock domain).
// Waits until a whole frame is buffered in the FIFO, then drains exactly one
// frame into a 2-entry output buffer that feeds a valid/ready sink. Samples are
// tagged with start-of-frame (m_sop) and end-of-frame (m_eop) markers, and
// completed frames are counted.
//
// Ports:
//   clk, rst_n           read clock, asynchronous active-low reset
//   enable               level, keep scheduling frames while high
//   cfg_frame_len        frame length in samples (1 .. 2^ADDR_W-1)
//   fifo_rden            FIFO read enable (data returns one cycle later)
//   fifo_rddata          FIFO read data
//   fifo_rdempty/full    FIFO read-side flags
//   fifo_rdusedw         FIFO read-side fill level
//   m_valid/m_ready      output handshake
//   m_data/m_sop/m_eop   output sample and frame markers
//   busy                 frame in progress
//   frame_cnt            completed frames (wrapping)
//   cfg_err              sticky, frame start attempted with zero length
module fifo_frame_rd_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] cfg_frame_len,
  output logic              fifo_rden,
  input  logic [DATA_W-1:0] fifo_rddata,
  input  logic              fifo_rdempty,
  input  logic              fifo_rdfull,
  input  logic [ADDR_W-1:0] fifo_rdusedw,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sop,
  output logic              m_eop,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StBurst = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0]   out_cnt_q, out_cnt_d;
  logic                inflight_q;
  logic [1:0]          occ_q, occ_d;
  logic [DATA_W-1:0]   buf0_q, buf0_d;
  logic [DATA_W-1:0]   buf1_q, buf1_d;
  logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic                cfg_err_q, cfg_err_d;

  logic [ADDR_W:0]     avail;
  logic                pop;
  logic                push;
  logic [2:0]          pending;
  logic                room;

  // A full FIFO reports usedw == 0, so the full flag supplies the top bit.
  assign avail = fifo_rdfull ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, fifo_rdusedw};

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf0_q;
  assign m_sop   = m_valid && (out_cnt_q == '0);
  assign m_eop   = m_valid && (out_cnt_q == (len_q - ADDR_W'(1)));
  assign pop     = m_valid && m_ready;
  // Data for last cycle's read lands in the buffer at the end of this cycle.
  assign push    = inflight_q;

  // Entries held or already on their way must leave a slot for a new read:
  // occ - pop + inflight < 2, rearranged to stay unsigned.
  assign pending = {1'b0, occ_q} + {2'b00, inflight_q};
  assign room    = pending < (3'd2 + {2'b00, pop});

  assign fifo_rden = (state_q == StBurst) && !fifo_rdempty && (rd_cnt_q < len_q) && room;

  assign busy      = (state_q == StBurst) || (state_q == StDrain);
  assign frame_cnt = frame_cnt_q;
  assign cfg_err   = cfg_err_q;

  // Frame control FSM and counters.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    rd_cnt_d    = rd_cnt_q;
    out_cnt_d   = out_cnt_q;
    frame_cnt_d = frame_cnt_q;
    cfg_err_d   = cfg_err_q;

    if (fifo_rden) begin
      rd_cnt_d = rd_cnt_q + ADDR_W'(1);
    end
    if (pop) begin
      out_cnt_d = out_cnt_q + ADDR_W'(1);
    end

    case (state_q)
      StIdle: begin
        if (enable) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (cfg_frame_len == '0) begin
          cfg_err_d = 1'b1;
        end else if (avail >= {1'b0, cfg_frame_len}) begin
          len_d     = cfg_frame_len;
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = StBurst;
        end
      end
      StBurst: begin
        if (rd_cnt_q == len_q) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_eop) begin
          frame_cnt_d = frame_cnt_q + FCNT_W'(1);
          state_d     = enable ? StWait : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Two-entry output buffer; buf0 is always the head.
  always_comb begin
    occ_d  = occ_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          buf0_d = fifo_rddata;
        end else begin
          buf1_d = fifo_rddata;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_rddata;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_rddata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      frame_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rd_cnt_q    <= rd_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= fifo_rden;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      frame_cnt_q <= frame_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_fifo_frame_rd_ctrl.sv
// Self-checking bench for fifo_frame_rd_ctrl. A queue-style FIFO model feeds
// the DUT; every accepted output sample is logged and compared against the
// expected stream: the written samples in order, cut into frames of the
// configured length with sop on the first and eop on the last of each frame.
module tb_fifo_frame_rd_ctrl;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int FW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [AW-1:0] cfg_frame_len = '0;
  logic          fifo_rden;
  logic [DW-1:0] fifo_rddata = '0;
  logic          fifo_rdempty;
  logic          fifo_rdfull;
  logic [AW-1:0] fifo_rdusedw;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_sop;
  logic          m_eop;
  logic          busy;
  logic [FW-1:0] frame_cnt;
  logic          cfg_err;

  fifo_frame_rd_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FCNT_W(FW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .cfg_frame_len(cfg_frame_len),
    .fifo_rden    (fifo_rden),
    .fifo_rddata  (fifo_rddata),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdfull  (fifo_rdfull),
    .fifo_rdusedw (fifo_rdusedw),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_sop        (m_sop),
    .m_eop        (m_eop),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .cfg_err      (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;
  int cyc = 0;
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: random

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FIFO model: write pointer owned by the tasks, read pointer by the model.
  logic [DW-1:0] mem [0:255];
  int wr_total = 0;
  int rd_total = 0;
  assign fifo_rdempty = (wr_total == rd_total);
  assign fifo_rdfull  = (wr_total - rd_total) >= 128;
  assign fifo_rdusedw = AW'(wr_total - rd_total);

  always @(posedge clk) begin
    if (fifo_rden && (wr_total != rd_total)) begin
      fifo_rddata <= mem[rd_total % 256];
      rd_total    <= rd_total + 1;
    end
  end

  task automatic write_sample(input logic [DW-1:0] d);
    mem[wr_total % 256] = d;
    wr_total++;
  endtask

  task automatic flush_fifo();
    wr_total = rd_total;
  endtask

  // Sink readiness is updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       m_ready = ~m_ready;
      2:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = 1'b1;
    endcase
  end

  // Monitor: logs accepted samples and protocol violations at the falling edge.
  logic [DW-1:0] obs_data [$];
  bit            obs_sop  [$];
  bit            obs_eop  [$];
  int            obs_cyc  [$];
  int            rd_seen = 0;
  int            viol_empty = 0;
  int            viol_occ = 0;
  int            viol_stable = 0;
  int            outstanding = 0;
  logic          pv = 0, pr = 0, ps = 0, pe = 0, prst = 0;
  logic [DW-1:0] pd = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      outstanding = 0;
    end else begin
      if (fifo_rden) begin
        rd_seen++;
        if (fifo_rdempty) viol_empty++;
      end
      // Samples read but not yet delivered may never exceed the buffer.
      outstanding = outstanding + (fifo_rden ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      if (outstanding > 2 || outstanding < 0) viol_occ++;
      if (prst && pv && !pr) begin
        if (!m_valid || m_data !== pd || m_sop !== ps || m_eop !== pe) viol_stable++;
      end
      if (m_valid && m_ready) begin
        obs_data.push_back(m_data);
        obs_sop.push_back(m_sop);
        obs_eop.push_back(m_eop);
        obs_cyc.push_back(cyc);
      end
    end
    pv = m_valid; pr = m_ready; ps = m_sop; pe = m_eop; pd = m_data; prst = rst_n;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_pops(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      if (obs_data.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step(1);
      if (!busy && !m_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(3);
    @(negedge clk);
    checks++;
    if ({m_valid, fifo_rden, m_sop, m_eop, busy, cfg_err} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b, required 000000",
               {m_valid, fifo_rden, m_sop, m_eop, busy, cfg_err});
    end
    checks++;
    if (frame_cnt !== '0) begin
      failures++;
      $display("FAIL reset_frame_cnt: got %0d, required 0", frame_cnt);
    end
    checks++;
    if (m_data !== '0) begin
      failures++;
      $display("FAIL reset_m_data: got %h, required 00", m_data);
    end
    step(1);
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_two_frames();
    logic [DW-1:0] exp [$];
    int  base, k_rden, k_valid, len;
    logic v_sop;
    logic [DW-1:0] v_data;
    bit  ok;
    len  = 4;
    base = obs_data.size();
    cfg_frame_len = AW'(len);
    for (int i = 0; i < 8; i++) begin
      exp.push_back(DW'(8'h10 + i));
      write_sample(DW'(8'h10 + i));
    end
    step(1);
    enable = 1'b1;
    k_rden = 0; k_valid = 0; v_sop = 0; v_data = '0;
    for (int k = 1; k <= 20 && k_valid == 0; k++) begin
      @(negedge clk);
      if (fifo_rden && k_rden == 0) k_rden = k;
      if (m_valid) begin
        k_valid = k; v_sop = m_sop; v_data = m_data;
      end
    end
    checks++;
    if (k_rden !== 3) begin
      failures++;
      $display("FAIL latency_rden: got cycle %0d, required 3", k_rden);
    end
    checks++;
    if (k_valid !== 5) begin
      failures++;
      $display("FAIL latency_valid: got cycle %0d, required 5", k_valid);
    end
    checks++;
    if (v_sop !== 1'b1 || v_data !== 8'h10) begin
      failures++;
      $display("FAIL first_sample: got sop=%b data=%h, required sop=1 data=10", v_sop, v_data);
    end
    wait_pops(base + 8, 100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL two_frames_timeout: got %0d, required %0d", obs_data.size() - base, 8);
    end
    for (int i = 0; i < 8 && base + i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[base+i] !== exp[i] || obs_sop[base+i] !== (i % len == 0)
          || obs_eop[base+i] !== (i % len == len - 1)) begin
        failures++;
        $display("FAIL two_frames[%0d]: got %h/%b/%b, required %h/%b/%b", i, obs_data[base+i],
                 obs_sop[base+i], obs_eop[base+i], exp[i], i % len == 0, i % len == len - 1);
      end
    end
    if (ok) begin
      checks++;
      if (obs_cyc[base+3] - obs_cyc[base] !== 3 || obs_cyc[base+7] - obs_cyc[base+4] !== 3) begin
        failures++;
        $display("FAIL throughput: got spans %0d and %0d, required 3 and 3",
                 obs_cyc[base+3] - obs_cyc[base], obs_cyc[base+7] - obs_cyc[base+4]);
      end
    end
    enable = 1'b0;
    wait_idle(50, ok);
    exp_frames += 2;
    checks++;
    if (frame_cnt !== FW'(exp_frames)) begin
      failures++;
      $display("FAIL two_frames_cnt: got %0d, required %0d", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_threshold();
    logic [DW-1:0] exp [$];
    logic [DW-1:0] d;
    int  base, rd0, len;
    bit  ok;
    len = 8;
    cfg_frame_len = AW'(len);
    base = obs_data.size();
    for (int i = 0; i < 7; i++) begin
      d = DW'($urandom);
      exp.push_back(d);
      write_sample(d);
    end
    rd0 = rd_seen;
    enable = 1'b1;
    step(20);
    checks++;
    if (rd_seen !== rd0 || obs_data.size() !== base || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL threshold_hold: got reads=%0d pops=%0d valid=%b, required 0 0 0",
               rd_seen - rd0, obs_data.size() - base, m_valid);
    end
    d = DW'($urandom);
    exp.push_back(d);
    write_sample(d);
    wait_pops(base + len, 100, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL threshold_timeout: got %0d, required %0d", obs_data.size() - base, len);
    end
    for (int i = 0; i < len && base + i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[base+i] !== exp[i] || obs_sop[base+i] !== (i == 0)
          || obs_eop[base+i] !== (i == len - 1)) begin
        failures++;
        $display("FAIL threshold[%0d]: got %h/%b/%b, required %h/%b/%b", i, obs_data[base+i],
                 obs_sop[base+i], obs_eop[base+i], exp[i], i == 0, i == len - 1);
      end
    end
    enable = 1'b0;
    wait_idle(50, ok);
    exp_frames += 1;
    checks++;
    if (frame_cnt !== FW'(exp_frames)) begin
      failures++;
      $display("FAIL threshold_cnt: got %0d, required %0d", frame_cnt, exp_frames);
    end
  endtask

  // Shared by the back-pressure and full-FIFO scenarios: n samples, frames of len.
  task automatic test_stream(input string name, input int len, input int n, input int mode);
    logic [DW-1:0] exp [$];
    logic [DW-1:0] d;
    int  base, ve, vo, vs;
    bit  ok;
    cfg_frame_len = AW'(len);
    base = obs_data.size();
    ve = viol_empty; vo = viol_occ; vs = viol_stable;
    for (int i = 0; i < n; i++) begin
      d = DW'($urandom);
      exp.push_back(d);
      write_sample(d);
    end
    ready_mode = mode;
    enable = 1'b1;
    wait_pops(base + (n / len) * len, 3000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_timeout: got %0d, required %0d", name, obs_data.size() - base,
               (n / len) * len);
    end
    for (int i = 0; i < (n / len) * len && base + i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[base+i] !== exp[i] || obs_sop[base+i] !== (i % len == 0)
          || obs_eop[base+i] !== (i % len == len - 1)) begin
        failures++;
        $display("FAIL %s[%0d]: got %h/%b/%b, required %h/%b/%b", name, i, obs_data[base+i],
                 obs_sop[base+i], obs_eop[base+i], exp[i], i % len == 0, i % len == len - 1);
      end
    end
    enable = 1'b0;
    wait_idle(50, ok);
    ready_mode = 0;
    step(2);
    checks++;
    if (obs_data.size() - base !== (n / len) * len) begin
      failures++;
      $display("FAIL %s_count: got %0d samples, required %0d", name, obs_data.size() - base,
               (n / len) * len);
    end
    checks++;
    if (viol_empty !== ve || viol_occ !== vo || viol_stable !== vs) begin
      failures++;
      $display("FAIL %s_protocol: got empty=%0d occ=%0d stable=%0d violations, required 0",
               name, viol_empty - ve, viol_occ - vo, viol_stable - vs);
    end
    exp_frames += n / len;
    checks++;
    if (frame_cnt !== FW'(exp_frames)) begin
      failures++;
      $display("FAIL %s_cnt: got %0d, required %0d", name, frame_cnt, exp_frames);
    end
    flush_fifo();
  endtask

  task automatic test_enable_drop();
    logic [DW-1:0] exp [$];
    logic [DW-1:0] d;
    int  base, rd0;
    bit  ok;
    cfg_frame_len = AW'(5);
    base = obs_data.size();
    for (int i = 0; i < 5; i++) begin
      d = DW'($urandom);
      exp.push_back(d);
      write_sample(d);
    end
    enable = 1'b1;
    wait_pops(base + 2, 50, ok);
    enable = 1'b0;
    wait_pops(base + 5, 50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL enable_drop_timeout: got %0d, required 5", obs_data.size() - base);
    end
    for (int i = 0; i < 5 && base + i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[base+i] !== exp[i] || obs_eop[base+i] !== (i == 4)) begin
        failures++;
        $display("FAIL enable_drop[%0d]: got %h/%b, required %h/%b", i, obs_data[base+i],
                 obs_eop[base+i], exp[i], i == 4);
      end
    end
    wait_idle(50, ok);
    exp_frames += 1;
    rd0 = rd_seen;
    for (int i = 0; i < 5; i++) write_sample(DW'($urandom));
    step(10);
    checks++;
    if (rd_seen !== rd0 || busy !== 1'b0 || frame_cnt !== FW'(exp_frames)) begin
      failures++;
      $display("FAIL enable_drop_idle: got reads=%0d busy=%b cnt=%0d, required 0 0 %0d",
               rd_seen - rd0, busy, frame_cnt, exp_frames);
    end
    flush_fifo();
  endtask

  task automatic test_cfg_err();
    int rd0;
    cfg_frame_len = '0;
    for (int i = 0; i < 3; i++) write_sample(DW'($urandom));
    rd0 = rd_seen;
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL cfg_err_pre: got %b, required 0", cfg_err);
    end
    enable = 1'b1;
    step(10);
    checks++;
    if (cfg_err !== 1'b1 || rd_seen !== rd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL cfg_err: got err=%b reads=%0d busy=%b, required 1 0 0",
               cfg_err, rd_seen - rd0, busy);
    end
    enable = 1'b0;
    step(3);
    flush_fifo();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] exp [$];
    logic [DW-1:0] d;
    int  base, rd0;
    bit  ok;
    cfg_frame_len = AW'(20);
    base = obs_data.size();
    for (int i = 0; i < 20; i++) write_sample(DW'($urandom));
    enable = 1'b1;
    wait_pops(base + 3, 50, ok);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, fifo_rden, m_sop, m_eop, busy, cfg_err} !== 6'b0 || frame_cnt !== '0
        || m_data !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got flags=%b cnt=%0d data=%h, required 0 0 00",
               {m_valid, fifo_rden, m_sop, m_eop, busy, cfg_err}, frame_cnt, m_data);
    end
    enable = 1'b0;
    step(2);
    flush_fifo();
    rst_n = 1'b1;
    exp_frames = 0;
    rd0 = rd_seen;
    for (int i = 0; i < 10; i++) write_sample(DW'($urandom));
    step(10);
    checks++;
    if (frame_cnt !== '0 || busy !== 1'b0 || rd_seen !== rd0) begin
      failures++;
      $display("FAIL reset_mid_after: got cnt=%0d busy=%b reads=%0d, required 0 0 0",
               frame_cnt, busy, rd_seen - rd0);
    end
    flush_fifo();
    // A fresh frame after reset must start at sop, not mid-frame.
    cfg_frame_len = AW'(4);
    base = obs_data.size();
    for (int i = 0; i < 4; i++) begin
      d = DW'($urandom);
      exp.push_back(d);
      write_sample(d);
    end
    enable = 1'b1;
    wait_pops(base + 4, 50, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL reset_mid_restart_timeout: got %0d, required 4", obs_data.size() - base);
    end
    for (int i = 0; i < 4 && base + i < obs_data.size(); i++) begin
      checks++;
      if (obs_data[base+i] !== exp[i] || obs_sop[base+i] !== (i == 0)
          || obs_eop[base+i] !== (i == 3)) begin
        failures++;
        $display("FAIL reset_mid_restart[%0d]: got %h/%b/%b, required %h/%b/%b", i,
                 obs_data[base+i], obs_sop[base+i], obs_eop[base+i], exp[i], i == 0, i == 3);
      end
    end
    enable = 1'b0;
    wait_idle(50, ok);
    checks++;
    if (frame_cnt !== FW'(1)) begin
      failures++;
      $display("FAIL reset_mid_restart_cnt: got %0d, required 1", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_threshold();
    test_stream("backpressure", 6, 12, 1);
    test_stream("full_fifo", 127, 128, 2);
    test_enable_drop();
    test_cfg_err();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
